serving_ram_arb: RTL
====================

SERVING_RAM_ARB -- requirements
Module: serving_ram_arb

Interface
REQ-001 SHALL have parameter: aw, 8, byte address width of the shared RAM (depth 2**aw).
REQ-002 SHALL have port: i_clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port: i_rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports, requester 0: i_p0_adr input aw address; i_p0_dat input 8 write data; i_p0_we input 1 write(1)/read(0); i_p0_cyc input 1 request; o_p0_rdt output 8 read data; o_p0_ack output 1 completion strobe.
REQ-005 SHALL have ports, requester 1: i_p1_adr, i_p1_dat, i_p1_we, i_p1_cyc, o_p1_rdt, o_p1_ack, with the same widths and meanings as requester 0.
REQ-006 SHALL have RAM-side ports: o_ram_waddr output aw; o_ram_wdata output 8; o_ram_wen output 1; o_ram_raddr output aw; o_ram_ren output 1; i_ram_rdata input 8; i_ram_ack input 1 (RAM raises ack with valid rdata one cycle after ren).

Function
REQ-007 SHALL have FSM states IDLE, WRITE, READ, RWAIT, ACK; every output is registered.
REQ-008 IDLE: the arbiter samples cyc at edge E; with no cyc it stays in IDLE.
REQ-009 IDLE arbitration: one cyc high grants that port; both high grants the port not granted last (round-robin); the last-granted pointer updates on each grant.
REQ-010 On grant, the arbiter latches adr/dat/we of the winner and goes to WRITE (we=1) or READ (we=0).
REQ-011 WRITE: o_ram_wen=1 with the latched waddr/wdata for exactly one cycle; then ACK.
REQ-012 READ: o_ram_ren=1 with the latched raddr for exactly one cycle; then RWAIT.
REQ-013 RWAIT: on i_ram_ack=1, the arbiter captures i_ram_rdata into the granted port's o_pX_rdt and goes to ACK; otherwise it stays in RWAIT (no timeout).
REQ-014 ACK: o_pX_ack=1 for exactly one cycle on the granted port only; then IDLE.
REQ-015 Latency from the request-sampling edge to ack high SHALL be 2 cycles for a write and 3 cycles for a read when the RAM acks after one cycle.
REQ-016 Back-to-back access: the minimum spacing between acks is 3 cycles for writes and 4 cycles for reads.
REQ-017 Requesters hold cyc/adr/dat/we until ack; after the grant, input changes have no effect on the access in flight.
REQ-018 A cyc drop mid-access does not abort the access; its ack is still issued.
REQ-019 o_pX_rdt holds its last captured value until the next read by that port; writes do not change it.
REQ-020 o_ram_wen and o_ram_ren are never both high, and are never high outside WRITE/READ.
REQ-021 Address wrap: the arbiter passes addresses unmodified; address 2**aw-1 is legal.
REQ-022 Starvation freedom: with both cyc held continuously, grants alternate p0,p1,p0,...

Reset
REQ-023 i_rst=1 at an edge forces IDLE and sets the last-granted pointer to p1 (p0 wins the first tie).
REQ-024 i_rst=1 at an edge zeroes all outputs: acks, rdt, ram addr/data, wen, ren.
REQ-025 Reset mid-access abandons the access, with no ack and no further wen/ren; a RAM ack arriving after reset is ignored.

Structure
REQ-026 State encodings and the RAM read-latency constant SHALL live in shared package serving_pkg.
REQ-027 The round-robin 2-way picker SHALL be sub-module serving_rr2 (inputs: two requests, last-grant; output: one-hot grant); everything else stays flat.

Verification
REQ-028 Scenario: p0 write adr=0x00 dat=0xA5 -> wen high 1 cycle with waddr=0x00 wdata=0xA5; p0_ack 2 cycles after sampling; p1_ack stays 0.
REQ-029 Scenario: p1 read adr=0x04 with RAM preloaded 0x5A -> ren 1 cycle with raddr=0x04; p1_rdt=0x5A with p1_ack 3 cycles after sampling.
REQ-030 Scenario: p0 and p1 cyc both high from reset, each writing its own address -> grant order p0,p1,p0,p1; acks strictly alternate with no overlap.
REQ-031 Scenario: p0 write 0x3C to adr=0x01, then p1 read adr=0x01 -> p1_rdt=0x3C.
REQ-032 Scenario: RAM ack delayed to 3 cycles after ren -> arbiter holds RWAIT, ack arrives 2 cycles later than nominal, and no second ren is issued.
REQ-033 Scenario: i_rst asserted in the cycle after a read grant -> no ack on either port, ram outputs 0, and the next p1 request is served normally.

Source files
------------

// File: rtl/serving_pkg.sv
// -----------------------------------------------------------------------------
// serving_pkg
//   Shared definitions for the two-port RAM arbiter:
//     state_t    - arbiter FSM state encoding
//     port_t     - requester identifier (used for grant/last-grant tracking)
//     RAM_RD_LAT - cycles from a RAM read strobe to the RAM's ack
// -----------------------------------------------------------------------------
package serving_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        RWAIT = 3'd3,
        ACK   = 3'd4
    } state_t;

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_t;

    // Nominal RAM read latency: ack with valid rdata one cycle after ren.
    localparam int RAM_RD_LAT = 1;

endpackage

// File: rtl/serving_ram_arb_if.sv
// -----------------------------------------------------------------------------
// serving_ram_arb_if
//   One requester's bus to the arbiter.
//     adr/dat/we/cyc - request (driven by the requester)
//     rdt/ack        - response (driven by the arbiter)
//   Modports: master = requester side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface serving_ram_arb_if #(
    parameter int aw = 8
);
    logic [aw-1:0] adr;
    logic [7:0]    dat;
    logic          we;
    logic          cyc;
    logic [7:0]    rdt;
    logic          ack;

    modport master (output adr, dat, we, cyc, input  rdt, ack);
    modport slave  (input  adr, dat, we, cyc, output rdt, ack);
endinterface

// File: rtl/serving_rr2.sv
// -----------------------------------------------------------------------------
// serving_rr2
//   Two-way round-robin picker (purely combinational).
//     req  - request vector, bit n = requester n
//     last - requester granted most recently
//     gnt  - one-hot grant (all zero when nobody requests)
//   A lone request always wins; on a tie the requester not granted last wins.
// -----------------------------------------------------------------------------
module serving_rr2
    import serving_pkg::*;
(
    input  logic [1:0] req,
    input  port_t      last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last == PORT1) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/serving_ram_arb.sv
// -----------------------------------------------------------------------------
// serving_ram_arb
//   Arbitrates two 8-bit requesters onto one shared RAM with separate
//   write and read ports. One access is in flight at a time.
//
//   Ports
//     i_clk, i_rst            - clock, synchronous active-high reset
//     i_pN_adr/dat/we/cyc     - requester N request (held until ack)
//     o_pN_rdt, o_pN_ack      - requester N read data and completion strobe
//     o_ram_waddr/wdata/wen   - RAM write port
//     o_ram_raddr/ren         - RAM read port
//     i_ram_rdata, i_ram_ack  - RAM read response (ack one cycle after ren)
//
//   Timing (RAM answering after one cycle), E = request-sampling edge:
//     write: wen high E..E+1, ack high E+2..E+3
//     read : ren high E..E+1, rdt captured at E+2, ack high E+3..E+4
//   Strobes are registered on the transition into WRITE/READ so they are
//   high exactly while the FSM sits in those states; ack is registered out
//   of ACK, so the FSM is already back in IDLE during the ack cycle and the
//   next request can be sampled on the following edge.
// -----------------------------------------------------------------------------
module serving_ram_arb
    import serving_pkg::*;
#(
    parameter int aw = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [aw-1:0] i_p0_adr,
    input  logic [7:0]    i_p0_dat,
    input  logic          i_p0_we,
    input  logic          i_p0_cyc,
    output logic [7:0]    o_p0_rdt,
    output logic          o_p0_ack,
    input  logic [aw-1:0] i_p1_adr,
    input  logic [7:0]    i_p1_dat,
    input  logic          i_p1_we,
    input  logic          i_p1_cyc,
    output logic [7:0]    o_p1_rdt,
    output logic          o_p1_ack,
    output logic [aw-1:0] o_ram_waddr,
    output logic [7:0]    o_ram_wdata,
    output logic          o_ram_wen,
    output logic [aw-1:0] o_ram_raddr,
    output logic          o_ram_ren,
    input  logic [7:0]    i_ram_rdata,
    input  logic          i_ram_ack
);

    // ------------------------------------------------------------------
    // Requester buses
    // ------------------------------------------------------------------
    serving_ram_arb_if #(.aw(aw)) p0_bus ();
    serving_ram_arb_if #(.aw(aw)) p1_bus ();

    logic [7:0] p0_rdt_q, p1_rdt_q;
    logic       p0_ack_q, p1_ack_q;

    assign p0_bus.adr = i_p0_adr;
    assign p0_bus.dat = i_p0_dat;
    assign p0_bus.we  = i_p0_we;
    assign p0_bus.cyc = i_p0_cyc;
    assign p0_bus.rdt = p0_rdt_q;
    assign p0_bus.ack = p0_ack_q;

    assign p1_bus.adr = i_p1_adr;
    assign p1_bus.dat = i_p1_dat;
    assign p1_bus.we  = i_p1_we;
    assign p1_bus.cyc = i_p1_cyc;
    assign p1_bus.rdt = p1_rdt_q;
    assign p1_bus.ack = p1_ack_q;

    assign o_p0_rdt = p0_bus.rdt;
    assign o_p0_ack = p0_bus.ack;
    assign o_p1_rdt = p1_bus.rdt;
    assign o_p1_ack = p1_bus.ack;

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_t        state_q, state_d;
    port_t         last_q,  last_d;   // most recently granted requester
    port_t         sel_q,   sel_d;    // requester owning the access in flight

    logic [aw-1:0] waddr_q, waddr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic          wen_q,   wen_d;
    logic [aw-1:0] raddr_q, raddr_d;
    logic          ren_q,   ren_d;
    logic [7:0]    p0_rdt_d, p1_rdt_d;
    logic          p0_ack_d, p1_ack_d;

    assign o_ram_waddr = waddr_q;
    assign o_ram_wdata = wdata_q;
    assign o_ram_wen   = wen_q;
    assign o_ram_raddr = raddr_q;
    assign o_ram_ren   = ren_q;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic [1:0]    gnt;
    logic [aw-1:0] win_adr;
    logic [7:0]    win_dat;
    logic          win_we;

    serving_rr2 u_rr2 (
        .req  ({p1_bus.cyc, p0_bus.cyc}),
        .last (last_q),
        .gnt  (gnt)
    );

    assign win_adr = gnt[1] ? p1_bus.adr : p0_bus.adr;
    assign win_dat = gnt[1] ? p1_bus.dat : p0_bus.dat;
    assign win_we  = gnt[1] ? p1_bus.we  : p0_bus.we;

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned; that is what keeps this block free of latches.
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        sel_d    = sel_q;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        raddr_d  = raddr_q;
        wen_d    = 1'b0;
        ren_d    = 1'b0;
        p0_rdt_d = p0_rdt_q;
        p1_rdt_d = p1_rdt_q;
        p0_ack_d = 1'b0;
        p1_ack_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (|gnt) begin
                    // Everything the access needs is captured here, so the
                    // requester's inputs are irrelevant until the next grant.
                    sel_d  = gnt[1] ? PORT1 : PORT0;
                    last_d = sel_d;
                    if (win_we) begin
                        state_d = WRITE;
                        wen_d   = 1'b1;
                        waddr_d = win_adr;
                        wdata_d = win_dat;
                    end else begin
                        state_d = READ;
                        ren_d   = 1'b1;
                        raddr_d = win_adr;
                    end
                end
            end

            WRITE: state_d = ACK;

            READ:  state_d = RWAIT;

            RWAIT: begin
                // No timeout: a slow RAM simply stretches this state.
                if (i_ram_ack) begin
                    state_d = ACK;
                    if (sel_q == PORT1) p1_rdt_d = i_ram_rdata;
                    else                p0_rdt_d = i_ram_rdata;
                end
            end

            ACK: begin
                state_d  = IDLE;
                p0_ack_d = (sel_q == PORT0);
                p1_ack_d = (sel_q == PORT1);
            end

            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            // Reset abandons any access in flight; a late RAM ack lands in
            // IDLE, which never looks at it.
            state_q  <= IDLE;
            last_q   <= PORT1;
            sel_q    <= PORT0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            wen_q    <= 1'b0;
            raddr_q  <= '0;
            ren_q    <= 1'b0;
            p0_rdt_q <= '0;
            p1_rdt_q <= '0;
            p0_ack_q <= 1'b0;
            p1_ack_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            sel_q    <= sel_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            wen_q    <= wen_d;
            raddr_q  <= raddr_d;
            ren_q    <= ren_d;
            p0_rdt_q <= p0_rdt_d;
            p1_rdt_q <= p1_rdt_d;
            p0_ack_q <= p0_ack_d;
            p1_ack_q <= p1_ack_d;
        end
    end

endmodule
